// File: rtl/rom_stream_reader.sv
// rom_stream_reader: walks an inclusive, possibly wrapping address range of a
// synchronous ROM and presents each word on a valid/ready stream.
module rom_stream_reader #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_SEND,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  cur_q, cur_d;
  logic [ADDR_W-1:0]  last_q, last_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]  cur_inc;

  // Next address wraps naturally at DEPTH because the sum is ADDR_W bits wide.
  assign cur_inc = cur_q + ADDR_W'(1);

  // State and datapath registers; reset aborts any range in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      last_q      <= '0;
      rom_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      last_q      <= last_d;
      rom_addr_q  <= rom_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Sequencer: issue address, wait out ROM latency, capture, then hand off.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    last_d      = last_q;
    rom_addr_d  = rom_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cur_d      = first_addr;
          last_d     = last_addr;
          rom_addr_d = first_addr;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        out_data_d  = rom_data;
        out_valid_d = 1'b1;
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (cur_q == last_q) begin
            state_d = ST_DONE;
          end else begin
            cur_d      = cur_inc;
            rom_addr_d = cur_inc;
            state_d    = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rom_addr  = rom_addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_rom_stream_reader.sv
// Scoreboard bench for rom_stream_reader with a behavioural 4x4 ROM (E,2,F,4).
module tb_rom_stream_reader;
  localparam int AW = 2;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] first_addr, last_addr, rom_addr;
  logic [DW-1:0] rom_data, out_data;
  logic          out_valid, out_ready, busy, done;

  always #5 clk = ~clk;

  rom_stream_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .first_addr(first_addr),
    .last_addr (last_addr),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  logic [DW-1:0] rom_mem [4];
  initial begin
    rom_mem[0] = 4'hE;
    rom_mem[1] = 4'h2;
    rom_mem[2] = 4'hF;
    rom_mem[3] = 4'h4;
  end

  // Synchronous ROM: one-cycle registered read.
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int last_hs_cyc = -1;
  bit spacing_en = 1'b0;
  logic [DW-1:0] exp_data_q [$];
  logic [AW-1:0] exp_addr_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input logic [AW-1:0] a);
    exp_data_q.push_back(d);
    exp_addr_q.push_back(a);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every handshake pops one expected word and its ROM address.
  always @(negedge clk) begin
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_data_q.size() == 0) begin
        check("unexpected_word", 32'(out_data), 32'hFFFF);
      end else begin
        check("word_data", 32'(out_data), 32'(exp_data_q.pop_front()));
        check("word_rom_addr", 32'(rom_addr), 32'(exp_addr_q.pop_front()));
      end
      if (spacing_en && last_hs_cyc >= 0)
        check("word_spacing", cyc - last_hs_cyc, 3);
      hs_cnt++;
      last_hs_cyc = cyc;
    end
  end

  // Start a range and check out_valid rises on the third edge after start goes high.
  task automatic start_range(input logic [AW-1:0] f, input logic [AW-1:0] l);
    hs_cnt = 0;
    last_hs_cyc = -1;
    first_addr = f;
    last_addr = l;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("lat_fetch_valid", out_valid, 0);
    check("lat_fetch_busy", busy, 1);
    tick();
    @(negedge clk);
    check("lat_latch_valid", out_valid, 0);
    tick();
    @(negedge clk);
    check("lat_send_valid", out_valid, 1);
  endtask

  task automatic wait_done(input int exp_hs);
    bit seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", seen, 1);
    if (seen) begin
      check("done_after_last_word", cyc - last_hs_cyc, 1);
      check("busy_in_done", busy, 1);
      check("handshake_count", hs_cnt, exp_hs);
      check("scoreboard_empty", exp_data_q.size(), 0);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("busy_idle", busy, 0);
    end
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("quiet_valid", out_valid, 0);
      check("quiet_busy", busy, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    first_addr = '0;
    last_addr = '0;
    tick();
    tick();
    check("rst_rom_addr", rom_addr, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    tick();

    // Full range with steady ready: E,2,F,4 every 3 clk.
    out_ready = 1'b1;
    push_exp(4'hE, 2'd0); push_exp(4'h2, 2'd1); push_exp(4'hF, 2'd2); push_exp(4'h4, 2'd3);
    spacing_en = 1'b1;
    start_range(2'd0, 2'd3);
    wait_done(4);
    spacing_en = 1'b0;
    tick();

    // Wrapping range 3..1.
    push_exp(4'h4, 2'd3); push_exp(4'hE, 2'd0); push_exp(4'h2, 2'd1);
    start_range(2'd3, 2'd1);
    wait_done(3);
    tick();

    // Single word plus an ignored start while busy.
    push_exp(4'hF, 2'd2);
    start_range(2'd2, 2'd2);
    first_addr = 2'd0;
    last_addr = 2'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1);
    quiet(10);
    tick();

    // Downstream stall for 5 clk on the first word.
    out_ready = 1'b0;
    push_exp(4'hE, 2'd0); push_exp(4'h2, 2'd1);
    start_range(2'd0, 2'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_data", out_data, 4'hE);
      check("stall_rom_addr", rom_addr, 0);
      check("stall_valid", out_valid, 1);
      tick();
    end
    out_ready = 1'b1;
    wait_done(2);
    tick();

    // Reset while the second word waits in SEND.
    out_ready = 1'b0;
    push_exp(4'hE, 2'd0);
    start_range(2'd0, 2'd3);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check("second_word_valid", found, 1);
    check("second_word_data", out_data, 4'h2);
    #2;
    reset = 1'b1;
    #1;
    check("arst_rom_addr", rom_addr, 0);
    check("arst_out_data", out_data, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    tick();
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    quiet(10);
    check("arst_scoreboard_empty", exp_data_q.size(), 0);

    // Back-to-back: new start in the IDLE cycle right after done.
    push_exp(4'h2, 2'd1); push_exp(4'hF, 2'd2);
    start_range(2'd1, 2'd2);
    wait_done(2);
    push_exp(4'h4, 2'd3);
    start_range(2'd3, 2'd3);
    wait_done(1);
    quiet(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
